watch_time_cnt: RTL and testbench

Stopwatch time-base counter directly downstream of the stopwatch control state machine. Consumes that machine's `clken` (count enable) and `rst` (synchronous clear). It divides the system clock down to 0.1 s ticks and keeps a cascaded BCD display time of M:SS.T, range 0:00.0 to 9:59.9 with wrap-around. Its digit outputs feed the display/decoder stage.

---
 rtl/watch_time_cnt.sv | 76 +++++++
 tb/tb_watch_time_cnt.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/watch_time_cnt.sv
// Stopwatch time base: prescales clk to 0.1 s ticks and keeps a cascaded BCD
// display time M:SS.T (0:00.0 .. 9:59.9, wrapping).
module watch_time_cnt #(
  parameter int unsigned PRESCALE = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rst,
  input  logic       clken,
  output logic [3:0] tenths,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       tick,
  output logic       rollover
);

  localparam logic [23:0] PS_LAST = 24'(PRESCALE - 1);

  logic [23:0] presc;
  logic        ps_done;
  logic        c_tenths;
  logic        c_sec_ones;
  logic        c_sec_tens;
  logic        c_min_ones;

  // Out-of-range digits count as "at last value" so they recover to 0.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] last);
    return (d >= last) ? 4'd0 : d + 4'd1;
  endfunction

  assign ps_done    = (presc >= PS_LAST);
  assign c_tenths   = (tenths >= 4'd9);
  assign c_sec_ones = c_tenths && (sec_ones >= 4'd9);
  assign c_sec_tens = c_sec_ones && (sec_tens >= 4'd5);
  assign c_min_ones = c_sec_tens && (min_ones >= 4'd9);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      tenths   <= '0;
      sec_ones <= '0;
      sec_tens <= '0;
      min_ones <= '0;
      tick     <= 1'b0;
      rollover <= 1'b0;
    end else if (rst) begin
      presc    <= '0;
      tenths   <= '0;
      sec_ones <= '0;
      sec_tens <= '0;
      min_ones <= '0;
      tick     <= 1'b0;
      rollover <= 1'b0;
    end else if (clken) begin
      if (ps_done) begin
        presc    <= '0;
        tick     <= 1'b1;
        rollover <= c_min_ones;
        tenths   <= bcd_inc(tenths, 4'd9);
        if (c_tenths)   sec_ones <= bcd_inc(sec_ones, 4'd9);
        if (c_sec_ones) sec_tens <= bcd_inc(sec_tens, 4'd5);
        if (c_sec_tens) min_ones <= bcd_inc(min_ones, 4'd9);
      end else begin
        presc    <= presc + 24'd1;
        tick     <= 1'b0;
        rollover <= 1'b0;
      end
    end else begin
      // Pause keeps the partial prescale count so no time is lost.
      tick     <= 1'b0;
      rollover <= 1'b0;
    end
  end

endmodule

// File: tb/tb_watch_time_cnt.sv
// Directed bench for watch_time_cnt: one instance at PRESCALE=10, one at
// PRESCALE=1, driven by the same control inputs.
module tb_watch_time_cnt;

  logic clk = 1'b0;
  logic reset, rst, clken;

  logic [3:0] t10, so10, st10, mo10;
  logic       tk10, ro10;
  logic [3:0] t1, so1, st1, mo1;
  logic       tk1, ro1;

  int total = 0;
  int bad   = 0;

  // per-run statistics
  int n_edges, n_tk10, n_tk1, n_ro1, first_tk10, ro1_edge;
  int ro_wo_tick, dbl_tick10, max_st1;
  logic prev_tk10;

  watch_time_cnt #(.PRESCALE(10)) u10 (
    .clk(clk), .reset(reset), .rst(rst), .clken(clken),
    .tenths(t10), .sec_ones(so10), .sec_tens(st10), .min_ones(mo10),
    .tick(tk10), .rollover(ro10)
  );

  watch_time_cnt #(.PRESCALE(1)) u1 (
    .clk(clk), .reset(reset), .rst(rst), .clken(clken),
    .tenths(t1), .sec_ones(so1), .sec_tens(st1), .min_ones(mo1),
    .tick(tk1), .rollover(ro1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    n_edges = 0; n_tk10 = 0; n_tk1 = 0; n_ro1 = 0;
    first_tk10 = -1; ro1_edge = -1;
    ro_wo_tick = 0; dbl_tick10 = 0; max_st1 = 0;
    prev_tk10 = 1'b0;
  endtask

  task automatic run(input int n, input logic en);
    clken = en;
    for (int i = 0; i < n; i++) begin
      step();
      n_edges++;
      if (tk10) begin
        n_tk10++;
        if (first_tk10 < 0) first_tk10 = n_edges;
        if (prev_tk10) dbl_tick10++;
      end
      prev_tk10 = tk10;
      if (tk1) n_tk1++;
      if (ro1) begin
        n_ro1++;
        ro1_edge = n_edges;
      end
      if ((ro1 && !tk1) || (ro10 && !tk10)) ro_wo_tick++;
      if (int'(st1) > max_st1) max_st1 = int'(st1);
    end
  endtask

  task automatic clear_pulse();
    rst = 1'b1;
    clken = 1'b0;
    step();
    rst = 1'b0;
    clr_stats();
  endtask

  function automatic int t_of(input logic [3:0] m, input logic [3:0] st,
                              input logic [3:0] so, input logic [3:0] t);
    return int'(m) * 1000 + int'(st) * 100 + int'(so) * 10 + int'(t);
  endfunction

  initial begin
    reset = 1'b1; rst = 1'b0; clken = 1'b0;
    clr_stats();
    step(); step();
    chk("reset_u10_time", t_of(mo10, st10, so10, t10), 0);
    chk("reset_u1_time",  t_of(mo1, st1, so1, t1), 0);
    reset = 1'b0;
    step();
    chk("post_release_flags", {tk10, ro10, tk1, ro1}, 0);

    // basic count
    clear_pulse();
    run(100, 1'b1);
    chk("basic_u10_time", t_of(mo10, st10, so10, t10), 10);
    chk("basic_u10_ticks", n_tk10, 10);
    chk("basic_u10_first_tick", first_tk10, 10);
    chk("basic_u10_dbl_tick", dbl_tick10, 0);
    chk("basic_u1_time", t_of(mo1, st1, so1, t1), 100);
    chk("basic_u1_ticks", n_tk1, 100);

    // pause / resume
    clear_pulse();
    run(7, 1'b1);
    chk("pause_pre_tenths", t10, 0);
    clr_stats();
    run(20, 1'b0);
    chk("pause_no_tick_u10", n_tk10, 0);
    chk("pause_no_tick_u1", n_tk1, 0);
    chk("pause_hold_u1", t_of(mo1, st1, so1, t1), 7);
    run(2, 1'b1);
    chk("resume_2_tenths", t10, 0);
    run(1, 1'b1);
    chk("resume_3_tenths", t10, 1);
    chk("resume_3_tick", tk10, 1);

    // seconds carry
    clear_pulse();
    run(599, 1'b1);
    chk("carry_599_u1", t_of(mo1, st1, so1, t1), 599);
    run(1, 1'b1);
    chk("carry_600_u1", t_of(mo1, st1, so1, t1), 1000);
    chk("carry_max_sec_tens", max_st1, 5);
    chk("carry_600_u10", t_of(mo10, st10, so10, t10), 60);

    // rollover
    clear_pulse();
    run(5999, 1'b1);
    chk("roll_5999_u1", t_of(mo1, st1, so1, t1), 9599);
    run(1, 1'b1);
    chk("roll_u1_time", t_of(mo1, st1, so1, t1), 0);
    chk("roll_u1_count", n_ro1, 1);
    chk("roll_u1_edge", ro1_edge, 6000);
    chk("roll_with_tick", {ro1, tk1}, 3);
    chk("roll_without_tick", ro_wo_tick, 0);
    chk("roll_u10_time", t_of(mo10, st10, so10, t10), 1000);

    // clear priority at terminal count, digits 0:05.9
    clear_pulse();
    run(599, 1'b1);
    chk("prio_pre_u10", t_of(mo10, st10, so10, t10), 59);
    rst = 1'b1;
    clken = 1'b1;
    step();
    rst = 1'b0;
    chk("prio_u10_time", t_of(mo10, st10, so10, t10), 0);
    chk("prio_u10_tick", tk10, 0);
    clr_stats();
    run(9, 1'b1);
    chk("prio_presc0_9", n_tk10, 0);
    run(1, 1'b1);
    chk("prio_presc0_10", {tk10, t10}, 5'b1_0001);

    // async reset mid-cycle at 3:27.4
    clear_pulse();
    run(2074, 1'b1);
    chk("areset_pre_u1", t_of(mo1, st1, so1, t1), 3274);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_u1_time", t_of(mo1, st1, so1, t1), 0);
    chk("areset_flags", {tk10, ro10, tk1, ro1}, 0);
    chk("areset_u10_time", t_of(mo10, st10, so10, t10), 0);
    clken = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("areset_release", t_of(mo1, st1, so1, t1) + int'(tk1), 0);
    clr_stats();
    run(10, 1'b1);
    chk("areset_restart_first", first_tk10, 10);
    chk("areset_restart_u10", t10, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
